// File: rtl/spi_frame_sched.sv
// spi_frame_sched: packs FIFO sample bytes into fixed-length SPI frames
// led by a sequence/overflow header, with a guaranteed inter-frame gap.
module spi_frame_sched #(
  parameter int FRAME_BYTES = 16,
  parameter int SCK_DIV     = 2,
  parameter int GAP_CYCLES  = 8
) (
  input  logic       MCU_CLK_25_000,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic [5:0] FIFO_LEVEL,
  input  logic [7:0] FIFO_DATA,
  input  logic       FIFO_OVF,
  output logic       FIFO_RD,
  output logic       MCU_SS,
  output logic       MCU_SCK,
  output logic       MCU_MOSI,
  output logic       BUSY,
  output logic       FRAME_DONE
);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, GAP
  } state_t;

  localparam logic [3:0] DIV_M1  = 4'(SCK_DIV - 1);
  localparam logic [7:0] GAP_M1  = 8'(GAP_CYCLES - 1);
  localparam logic [5:0] N_BYTES = 6'(FRAME_BYTES);

  state_t     state;
  logic [3:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [5:0] byte_cnt;
  logic [7:0] gap_cnt;
  logic [7:0] sh_reg;
  logic [7:0] pf_reg;
  logic       rd_q;
  logic       ovf_seen;
  logic [3:0] seq;
  logic       div_end;

  assign div_end = (div_cnt == DIV_M1);

  always_ff @(posedge MCU_CLK_25_000) begin
    if (!RESET_N) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      gap_cnt    <= '0;
      sh_reg     <= '0;
      pf_reg     <= '0;
      rd_q       <= 1'b0;
      ovf_seen   <= 1'b0;
      seq        <= '0;
      FIFO_RD    <= 1'b0;
      MCU_SS     <= 1'b1;
      MCU_SCK    <= 1'b0;
      MCU_MOSI   <= 1'b0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      FIFO_RD    <= 1'b0;
      FRAME_DONE <= 1'b0;
      rd_q       <= FIFO_RD;
      if (rd_q)
        pf_reg <= FIFO_DATA;
      if (FIFO_OVF)
        ovf_seen <= 1'b1;
      unique case (state)
        IDLE: begin
          if (ENABLE && FIFO_LEVEL >= N_BYTES) begin
            state    <= SETUP;
            MCU_SS   <= 1'b0;
            BUSY     <= 1'b1;
            FIFO_RD  <= 1'b1;
            sh_reg   <= {2'b10, ovf_seen, 1'b0, seq};
            MCU_MOSI <= 1'b1;
            ovf_seen <= FIFO_OVF;
            div_cnt  <= '0;
            bit_cnt  <= 3'd7;
            byte_cnt <= '0;
          end
        end
        SETUP: begin
          if (div_end) begin
            state   <= SHIFT;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 4'd1;
          end
        end
        SHIFT: begin
          if (!div_end) begin
            div_cnt <= div_cnt + 4'd1;
          end else begin
            div_cnt <= '0;
            MCU_SCK <= ~MCU_SCK;
            // everything below happens on the SCK falling edge
            if (MCU_SCK) begin
              if (bit_cnt != 3'd0) begin
                bit_cnt  <= bit_cnt - 3'd1;
                sh_reg   <= {sh_reg[6:0], 1'b0};
                MCU_MOSI <= sh_reg[6];
              end else if (byte_cnt == N_BYTES) begin
                state <= HOLD;
              end else begin
                byte_cnt <= byte_cnt + 6'd1;
                bit_cnt  <= 3'd7;
                sh_reg   <= pf_reg;
                MCU_MOSI <= pf_reg[7];
                FIFO_RD  <= (byte_cnt + 6'd1 != N_BYTES);
              end
            end
          end
        end
        HOLD: begin
          if (div_end) begin
            state      <= GAP;
            div_cnt    <= '0;
            gap_cnt    <= '0;
            MCU_SS     <= 1'b1;
            MCU_MOSI   <= 1'b0;
            FRAME_DONE <= 1'b1;
            seq        <= seq + 4'd1;
          end else begin
            div_cnt <= div_cnt + 4'd1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_M1) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_frame_sched.md
SPI_FRAME_SCHED -- requirements
Module: spi_frame_sched

Interface
REQ-001 Parameter FRAME_BYTES, default 16, SHALL set the number of payload bytes per SPI frame (range 1..32).
REQ-002 Parameter SCK_DIV, default 2, SHALL set the SCK half-period in MCU_CLK_25_000 cycles (range 1..15).
REQ-003 Parameter GAP_CYCLES, default 8, SHALL set the minimum number of cycles MCU_SS stays high between frames (range 1..255).
REQ-004 MCU_CLK_25_000  input  1  SHALL be the single clock; all logic is clocked on its rising edge.
REQ-005 RESET_N  input  1  SHALL be the synchronous, active-low reset.
REQ-006 ENABLE  input  1  SHALL permit new frames to start while high.
REQ-007 FIFO_LEVEL  input  6  SHALL be the number of sample bytes currently held in the upstream sample FIFO.
REQ-008 FIFO_DATA  input  8  SHALL be the FIFO read data, valid the cycle after FIFO_RD is high.
REQ-009 FIFO_OVF  input  1  SHALL be a one-cycle pulse from the FIFO indicating a dropped sample byte.
REQ-010 FIFO_RD  output  1  SHALL be a one-cycle read strobe to the FIFO.
REQ-011 MCU_SS  output  1  SHALL be the active-low SPI slave select.
REQ-012 MCU_SCK  output  1  SHALL be the SPI clock (mode 0: idle low, MCU samples on the rising edge).
REQ-013 MCU_MOSI  output  1  SHALL be the SPI data, MSB first.
REQ-014 BUSY  output  1  SHALL be high from frame start until the end of the inter-frame gap.
REQ-015 FRAME_DONE  output  1  SHALL pulse for one cycle when MCU_SS deasserts at the end of a frame.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD, GAP.
REQ-017 IDLE->SETUP SHALL occur when ENABLE=1 and FIFO_LEVEL>=FRAME_BYTES; on that edge MCU_SS goes low, the shift register loads the header byte, and FIFO_RD pulses once (prefetch of payload byte 0).
REQ-018 Header byte SHALL be {2'b10, ovf_seen, 1'b0, seq[3:0]}; seq is a 4-bit frame counter that wraps 15->0 and increments at each FRAME_DONE.
REQ-019 ovf_seen SHALL be set by any FIFO_OVF pulse, captured into the header at frame start, and cleared at that same edge unless FIFO_OVF is high in that cycle.
REQ-020 SETUP SHALL last SCK_DIV cycles with MCU_SCK low and MOSI = header MSB, then enter SHIFT.
REQ-021 In SHIFT each bit SHALL occupy 2*SCK_DIV cycles: SCK low for SCK_DIV cycles, then high for SCK_DIV cycles; MOSI changes only on the SCK falling edge (or at SETUP entry for bit 7 of the header).
REQ-022 At the first cycle of every byte except the last payload byte, FIFO_RD SHALL pulse once; the returned FIFO_DATA SHALL be captured into a prefetch register the following cycle.
REQ-023 At each byte boundary the shift register SHALL load the prefetch register; exactly FRAME_BYTES FIFO_RD pulses SHALL occur per frame.
REQ-024 After the final SCK falling edge of the last payload bit, HOLD SHALL keep MCU_SS low and MCU_SCK low for SCK_DIV cycles, then MCU_SS rises, FRAME_DONE pulses, and GAP is entered.
REQ-025 GAP SHALL last GAP_CYCLES cycles with MCU_SS high, then return to IDLE; BUSY drops on entering IDLE.
REQ-026 Frame length SHALL be SCK_DIV + (FRAME_BYTES+1)*16*SCK_DIV + SCK_DIV cycles from MCU_SS falling to rising.
REQ-027 ENABLE falling mid-frame SHALL NOT truncate the frame; only the next IDLE->SETUP is blocked.
REQ-028 FIFO_LEVEL is sampled only in IDLE; changes during a frame SHALL have no effect.
REQ-029 MOSI SHALL be held 0 whenever MCU_SS is high.

Reset
REQ-030 With RESET_N low at a clock edge the block SHALL enter IDLE with MCU_SS=1, MCU_SCK=0, MCU_MOSI=0, FIFO_RD=0, BUSY=0, FRAME_DONE=0, seq=0, ovf_seen=0, including when asserted mid-frame (frame aborted, no FRAME_DONE).

Verification
REQ-031 Defaults, FIFO_LEVEL=16, ENABLE=1, bytes 0x00..0x0F -> one frame, header 0x80, payload 0x00..0x0F MSB first, SS low for 548 cycles, 16 FIFO_RD pulses, one FRAME_DONE.
REQ-032 FIFO_LEVEL held at 32 for 17 frames -> headers 0x80..0x8F then 0x80 (seq wrap), SS high >=8 cycles between frames.
REQ-033 FIFO_OVF pulse during frame 0 -> frame 1 header 0xA1, frame 2 header 0x82.
REQ-034 FIFO_LEVEL=15 -> no frame, SS stays high, no FIFO_RD; raising to 16 -> frame starts next cycle.
REQ-035 RESET_N low for 1 cycle during payload byte 5 -> next edge SS=1, SCK=0, BUSY=0, no FRAME_DONE; next frame header 0x80.
REQ-036 SCK_DIV=1, FRAME_BYTES=1, ENABLE dropped during SHIFT -> frame of 34 cycles completes, FRAME_DONE pulses, no further frame.
